ascon_perm_seq: RTL and testbench

Iterative sequencer around the combinational Ascon permutation datapath. It holds the 320-bit state in registers and accepts a state plus a round-count selector over a valid/ready handshake. It drives the permutation core for 12 or 8 rounds, UROL rounds per cycle, then presents the permuted state over a second valid/ready handshake. It sits between the mode controller (AEAD/hash FSM) and the permutation core.

---
 rtl/ascon_perm_seq.sv | 115 +++++++++++
 tb/tb_ascon_perm_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - iterative round sequencer around the Ascon permutation core
// Holds the 320-bit state, steps the external core UROL rounds per cycle, hands back the result.
module ascon_perm_seq #(
  parameter int UROL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        p8_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic [3:0]  round_cnt_o,
  output logic [63:0] xp0_o,
  output logic [63:0] xp1_o,
  output logic [63:0] xp2_o,
  output logic [63:0] xp3_o,
  output logic [63:0] xp4_o,
  input  logic [63:0] xp0_i,
  input  logic [63:0] xp1_i,
  input  logic [63:0] xp2_i,
  input  logic [63:0] xp3_i,
  input  logic [63:0] xp4_i
);

  if (!(UROL == 1 || UROL == 2 || UROL == 4)) begin : g_urol_check
    $error("ascon_perm_seq: UROL must be 1, 2 or 4");
  end

  localparam logic [3:0] STEP = 4'(UROL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [63:0] s0, s1, s2, s3, s4;
  logic [3:0]  rnd;
  logic        out_valid;
  logic        accept;

  // DONE with a ready consumer frees the slot in the same cycle, so a new job can enter.
  assign in_ready_o = rst & ((state == IDLE) | ((state == DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            s0        <= x0_i;
            s1        <= x1_i;
            s2        <= x2_i;
            s3        <= x3_i;
            s4        <= x4_i;
            rnd       <= p8_i ? 4'd8 : 4'd12;
            out_valid <= 1'b0;
            state     <= RUN;
          end else if (state == DONE && out_ready_i) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RUN: begin
          s0  <= xp0_i;
          s1  <= xp1_i;
          s2  <= xp2_i;
          s3  <= xp3_i;
          s4  <= xp4_i;
          rnd <= rnd - STEP;
          if (rnd == STEP) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid;
  assign round_cnt_o = rnd;

  assign x0_o  = s0;
  assign x1_o  = s1;
  assign x2_o  = s2;
  assign x3_o  = s3;
  assign x4_o  = s4;
  assign xp0_o = s0;
  assign xp1_o = s1;
  assign xp2_o = s2;
  assign xp3_o = s3;
  assign xp4_o = s4;

endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb/tb_ascon_perm_seq.sv - self-checking bench for ascon_perm_seq at UROL 1, 2 and 4
// Each lane pairs a sequencer with a behavioural Ascon core; results go against a round-by-round model.
module tb_ascon_perm_seq;

  typedef logic [4:0][63:0] st_t;

  logic        clk;
  logic        rst;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [3:0]  rc        [3];
  logic [63:0] xo        [3][5];
  logic        p8;
  st_t         xi;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t ascon_round(input st_t s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    st_t o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 ^= 64'(((15 - r) << 4) | r);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  function automatic st_t ref_perm(input st_t s, input int first, input int n);
    st_t t = s;
    for (int i = 0; i < n; i++) t = ascon_round(t, first + i);
    return t;
  endfunction

  // The core derives its round index from the remaining-round count it is shown.
  function automatic st_t core_step(input st_t s, input logic [3:0] rcv, input int u);
    st_t t = s;
    for (int i = 0; i < u; i++)
      if (12 - int'(rcv) + i < 12) t = ascon_round(t, 12 - int'(rcv) + i);
    return t;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int U = 1 << g;
    st_t xp_out;
    st_t xp_in;
    ascon_perm_seq #(.UROL(U)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]), .p8_i(p8),
      .x0_i(xi[0]), .x1_i(xi[1]), .x2_i(xi[2]), .x3_i(xi[3]), .x4_i(xi[4]),
      .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
      .x0_o(xo[g][0]), .x1_o(xo[g][1]), .x2_o(xo[g][2]), .x3_o(xo[g][3]), .x4_o(xo[g][4]),
      .round_cnt_o(rc[g]),
      .xp0_o(xp_out[0]), .xp1_o(xp_out[1]), .xp2_o(xp_out[2]), .xp3_o(xp_out[3]), .xp4_o(xp_out[4]),
      .xp0_i(xp_in[0]), .xp1_i(xp_in[1]), .xp2_i(xp_in[2]), .xp3_i(xp_in[3]), .xp4_i(xp_in[4])
    );
    always_comb xp_in = core_step(xp_out, rc[g], U);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic st_t get_xo(input int l);
    st_t r;
    for (int i = 0; i < 5; i++) r[i] = xo[l][i];
    return r;
  endfunction

  function automatic st_t rnd_state();
    st_t r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic wait_done(input int l, input int rounds, input string tag);
    int n = 1;
    int u = 1 << l;
    int e;
    forever begin
      e = rounds - (n - 1) * u;
      if (e >= 0) chk({tag, "_rc"}, rc[l], 320'(e));
      if (out_valid[l] === 1'b1 || n > 20) break;
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, rounds / u + 1);
  endtask

  task automatic release_job(input int l, input string tag);
    out_ready[l] = 1'b1;
    #1;
    chk({tag, "_ready_pass"}, in_ready[l], 1'b1);
    tick();
    out_ready[l] = 1'b0;
    #1;
    chk({tag, "_valid_drop"}, out_valid[l], 1'b0);
    chk({tag, "_idle_ready"}, in_ready[l], 1'b1);
  endtask

  task automatic job(input int l, input st_t st, input bit p8v, input st_t exp,
                     input int stall, input string tag);
    xi = st;
    p8 = p8v;
    in_valid[l] = 1'b1;
    #1;
    chk({tag, "_accept_ready"}, in_ready[l], 1'b1);
    tick();
    in_valid[l] = 1'b0;
    xi = rnd_state();
    p8 = 1'($urandom);
    wait_done(l, p8v ? 8 : 12, tag);
    chk({tag, "_result"}, get_xo(l), exp);
    for (int k = 0; k < stall; k++) begin
      in_valid[l] = k[0];
      xi = rnd_state();
      tick();
      chk({tag, "_stall_valid"}, out_valid[l], 1'b1);
      chk({tag, "_stall_ready"}, in_ready[l], 1'b0);
      chk({tag, "_stall_state"}, get_xo(l), exp);
      chk({tag, "_stall_rc"}, rc[l], 4'd0);
    end
    in_valid[l] = 1'b0;
    release_job(l, tag);
  endtask

  task automatic b2b(input int l, input st_t a, input st_t b);
    xi = a;
    p8 = 1'b0;
    in_valid[l] = 1'b1;
    tick();
    in_valid[l] = 1'b0;
    wait_done(l, 12, "b2b_a");
    chk("b2b_a_result", get_xo(l), ref_perm(a, 0, 12));
    xi = b;
    p8 = 1'b1;
    in_valid[l] = 1'b1;
    out_ready[l] = 1'b1;
    #1;
    chk("b2b_ready_pass", in_ready[l], 1'b1);
    tick();
    in_valid[l] = 1'b0;
    out_ready[l] = 1'b0;
    xi = rnd_state();
    chk("b2b_valid_drop", out_valid[l], 1'b0);
    chk("b2b_run_ready", in_ready[l], 1'b0);
    wait_done(l, 8, "b2b_b");
    chk("b2b_b_result", get_xo(l), ref_perm(b, 4, 8));
    release_job(l, "b2b_b");
  endtask

  initial begin
    st_t kat_in, kat_out, a, b;
    bit seen;
    kat_in  = '0;
    kat_in[0] = 64'h00400c0000000100;
    kat_out[0] = 64'hee9398aadb67f03d;
    kat_out[1] = 64'h8bb21831c60f1002;
    kat_out[2] = 64'hb48a92db98d5da62;
    kat_out[3] = 64'h43189921b8f8e3e8;
    kat_out[4] = 64'h348fa5c9d525e140;

    rst = 1'b0;
    p8 = 1'b0;
    xi = rnd_state();
    for (int l = 0; l < 3; l++) begin
      in_valid[l]  = 1'b1;
      out_ready[l] = 1'($urandom);
    end

    for (int c = 0; c < 3; c++) begin
      tick();
      xi = rnd_state();
      p8 = 1'($urandom);
      #1;
      for (int l = 0; l < 3; l++) begin
        chk("rst_in_ready", in_ready[l], 1'b0);
        chk("rst_out_valid", out_valid[l], 1'b0);
        chk("rst_state", get_xo(l), '0);
        chk("rst_rc", rc[l], 4'd0);
      end
    end
    for (int l = 0; l < 3; l++) begin
      in_valid[l]  = 1'b0;
      out_ready[l] = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int l = 0; l < 3; l++) chk("rel_in_ready", in_ready[l], 1'b1);
    tick();
    for (int l = 0; l < 3; l++) begin
      chk("rel_in_ready_cycle", in_ready[l], 1'b1);
      chk("rel_no_accept_rc", rc[l], 4'd0);
      chk("rel_out_valid", out_valid[l], 1'b0);
    end

    for (int l = 0; l < 3; l++) job(l, kat_in, 1'b0, kat_out, 0, "kat_p12");

    for (int l = 0; l < 3; l++) begin
      a = rnd_state();
      job(l, a, 1'b1, ref_perm(a, 4, 8), (l == 1) ? 5 : 0, "rand_p8");
      a = rnd_state();
      job(l, a, 1'b0, ref_perm(a, 0, 12), (l == 2) ? 5 : 0, "rand_p12");
    end

    for (int l = 0; l < 3; l++) begin
      a = rnd_state();
      b = rnd_state();
      b2b(l, a, b);
    end

    a = rnd_state();
    xi = a;
    p8 = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_running_rc", rc[0], 4'd8);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready[0], 1'b0);
    tick();
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_state", get_xo(0), '0);
    chk("midrst_rc", rc[0], 4'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 1'b0);
    a = rnd_state();
    job(0, a, 1'b0, ref_perm(a, 0, 12), 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
